sfx_sequencer: RTL

- Audio controller for the Breakout top level. Accepts one-cycle sound-event requests from game logic (wall, paddle, brick, lose).
- Arbitrates requests by priority and plays each effect as a short fixed sequence of notes (do/re/mi/sol).
- Generates the 5-bit sine-ROM address stepping at each note's pitch, and an audio enable that gates the 4-bit tone output.
- Replaces the ad-hoc play_sound clock muxing in the top level.

---
 rtl/sfx_pkg.sv | 85 ++++++++
 rtl/sfx_tone_stepper.sv | 45 ++++
 rtl/sfx_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// Shared types and lookup tables for the Breakout sound-effect sequencer.
// Notes, effects and their fixed melodies live here so the FSM stays table-driven.
package sfx_pkg;

  localparam int CNT_W  = 23;
  localparam int STEP_W = 12;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    NOTE_REST = 3'd0,
    NOTE_DO   = 3'd1,
    NOTE_RE   = 3'd2,
    NOTE_MI   = 3'd3,
    NOTE_SOL  = 3'd4
  } note_t;

  // Effect index doubles as its priority: a larger value wins.
  typedef enum logic [1:0] {
    FX_WALL   = 2'd0,
    FX_PADDLE = 2'd1,
    FX_BRICK  = 2'd2,
    FX_LOSE   = 2'd3
  } effect_t;

  // Clock cycles per sine-ROM step, minus one.
  function automatic logic [STEP_W-1:0] note_step(input note_t n);
    logic [STEP_W-1:0] s;
    case (n)
      NOTE_DO:  s = 12'd2986;
      NOTE_RE:  s = 12'd2660;
      NOTE_MI:  s = 12'd2369;
      NOTE_SOL: s = 12'd1993;
      default:  s = 12'd0;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] effect_len(input effect_t e);
    logic [2:0] l;
    case (e)
      FX_WALL:   l = 3'd1;
      FX_PADDLE: l = 3'd2;
      FX_BRICK:  l = 3'd2;
      default:   l = 3'd4;
    endcase
    return l;
  endfunction

  function automatic note_t effect_note(input effect_t e, input logic [1:0] idx);
    note_t n;
    n = NOTE_REST;
    case (e)
      FX_WALL:   n = NOTE_SOL;
      FX_PADDLE: n = idx[0] ? NOTE_MI  : NOTE_DO;
      FX_BRICK:  n = idx[0] ? NOTE_SOL : NOTE_MI;
      FX_LOSE: begin
        case (idx)
          2'd0:    n = NOTE_SOL;
          2'd1:    n = NOTE_MI;
          2'd2:    n = NOTE_RE;
          default: n = NOTE_DO;
        endcase
      end
      default:   n = NOTE_REST;
    endcase
    return n;
  endfunction

  function automatic effect_t pick_effect(input logic [3:0] p);
    effect_t e;
    if (p[3])      e = FX_LOSE;
    else if (p[2]) e = FX_BRICK;
    else if (p[1]) e = FX_PADDLE;
    else           e = FX_WALL;
    return e;
  endfunction

endpackage

// File: rtl/sfx_tone_stepper.sv
// Pitch generator: walks the sine-ROM address once every (step_i + 1) enabled cycles.
// clear_i zeroes both counter and address; while disabled the address holds and the phase counter rests at 0.
module sfx_tone_stepper
  import sfx_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [ADDR_W-1:0] rom_addr_o
);

  logic [CNT_W-1:0]  tone_q, tone_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    tone_d = tone_q;
    addr_d = addr_q;
    if (clear_i) begin
      tone_d = '0;
      addr_d = '0;
    end else if (!enable_i) begin
      tone_d = '0;
    end else if (tone_q == {{(CNT_W-STEP_W){1'b0}}, step_i}) begin
      tone_d = '0;
      addr_d = addr_q + 5'd1;
    end else begin
      tone_d = tone_q + 23'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tone_q <= '0;
      addr_q <= '0;
    end else begin
      tone_q <= tone_d;
      addr_q <= addr_d;
    end
  end

  assign rom_addr_o = addr_q;

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: latches event pulses, arbitrates by priority and plays each
// effect as a fixed note melody with silent gaps, driving the sine-ROM address and audio enable.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 5_000_000,
  parameter int unsigned GAP_TICKS  = 500_000
) (
  input  logic        clk,
  input  logic        reset,
  // One-cycle pulses; any bit seen is remembered until its effect is loaded. No back-pressure.
  input  logic [3:0]  req,
  output logic [4:0]  rom_addr,
  output logic        audio_en,
  output logic        busy,
  output logic [1:0]  effect_id,
  output logic [2:0]  note,
  output state_t      dbg_state
);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  state_t           state_q, state_d;
  logic [3:0]       pending_q, pending_d;
  effect_t          effect_q, effect_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] dur_q, dur_d;

  logic [3:0]       pend_all;
  effect_t          sel;
  logic             preempt;
  logic             last_note;
  note_t            note_cur;
  logic             stp_clear;
  logic             stp_en;

  always_comb begin
    pend_all  = pending_q | req;
    sel       = pick_effect(pend_all);
    // Any request at or above the playing effect's priority takes over.
    preempt   = (pend_all >> effect_q) != 4'd0;
    last_note = ({1'b0, idx_q} == (effect_len(effect_q) - 3'd1));
    note_cur  = effect_note(effect_q, idx_q);
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pend_all;
    effect_d  = effect_q;
    idx_d     = idx_q;
    dur_d     = dur_q;
    stp_clear = 1'b0;
    stp_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_all != 4'd0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        effect_d  = sel;
        pending_d = pend_all & ~(4'b0001 << sel);
        idx_d     = 2'd0;
        dur_d     = '0;
        stp_clear = 1'b1;
        state_d   = ST_PLAY;
      end
      ST_PLAY: begin
        stp_en = 1'b1;
        if (preempt) begin
          state_d = ST_LOAD;
        end else if (dur_q == NOTE_LAST) begin
          dur_d = '0;
          if (!last_note)               state_d = ST_GAP;
          else if (pend_all != 4'd0)    state_d = ST_LOAD;
          else                          state_d = ST_IDLE;
        end else begin
          dur_d = dur_q + 23'd1;
        end
      end
      ST_GAP: begin
        if (preempt) begin
          state_d = ST_LOAD;
        end else if (dur_q == GAP_LAST) begin
          dur_d   = '0;
          idx_d   = idx_q + 2'd1;
          state_d = ST_PLAY;
        end else begin
          dur_d = dur_q + 23'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      effect_q  <= FX_WALL;
      idx_q     <= '0;
      dur_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      effect_q  <= effect_d;
      idx_q     <= idx_d;
      dur_q     <= dur_d;
    end
  end

  sfx_tone_stepper u_stepper (
    .clk_i      (clk),
    .rst_i      (reset),
    .clear_i    (stp_clear),
    .enable_i   (stp_en),
    .step_i     (note_step(note_cur)),
    .rom_addr_o (rom_addr)
  );

  // During LOAD the arbiter's choice is shown so effect_id is valid for every busy cycle.
  always_comb begin
    audio_en  = (state_q == ST_PLAY);
    busy      = (state_q != ST_IDLE);
    note      = audio_en ? note_cur : NOTE_REST;
    effect_id = (state_q == ST_LOAD) ? sel : effect_q;
    dbg_state = state_q;
  end

endmodule
